// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking, frame-aligned
// double-buffered value updates and optional leading-zero suppression.

module seg7_decoder (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);
   // Active-low hex glyphs, bit 6 = a ... bit 0 = g
   always_comb begin
      seg_o = 7'h7F;
      case (nibble_i)
         4'h0: seg_o = 7'h01;
         4'h1: seg_o = 7'h4F;
         4'h2: seg_o = 7'h12;
         4'h3: seg_o = 7'h06;
         4'h4: seg_o = 7'h4C;
         4'h5: seg_o = 7'h24;
         4'h6: seg_o = 7'h20;
         4'h7: seg_o = 7'h0F;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h04;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h60;
         4'hC: seg_o = 7'h31;
         4'hD: seg_o = 7'h42;
         4'hE: seg_o = 7'h30;
         default: seg_o = 7'h38;
      endcase
   end
endmodule

module seg7_scan_ctrl #(
   parameter int unsigned DIGIT_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        lz_en,
   output logic [3:0]  an,
   output logic [6:0]  a_to_g,
   output logic        dp,
   output logic        busy,
   output logic        frame_done
);
   localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

   logic [CW-1:0] slot_q, slot_d;
   logic [1:0]    digit_q, digit_d;
   logic [15:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic          pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;
   logic          busy_q, busy_d, frame_done_q, frame_done_d;

   logic          slot_last_c, boundary_c, lz_blank_c, drive_c;
   logic [3:0]    nibble_c;
   logic [6:0]    seg_c;
   phase_e        phase_c;

   assign slot_last_c = (slot_q == CW'(DIGIT_CYCLES - 1));
   assign boundary_c  = enable && slot_last_c && (digit_q == 2'd3);

   // Slot/digit scan and pending/display register transfer
   always_comb begin
      slot_d       = slot_q;
      digit_d      = digit_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_lz_d    = pend_lz_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      disp_lz_d    = disp_lz_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;

      if (!enable) begin
         slot_d  = '0;
         digit_d = 2'd0;
      end else if (slot_last_c) begin
         slot_d  = '0;
         digit_d = digit_q + 2'd1;
      end else begin
         slot_d  = slot_q + CW'(1);
      end

      if (boundary_c) begin
         frame_done_d = 1'b1;
         busy_d       = 1'b0;
         if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_in;
            disp_lz_d  = lz_en;
         end else begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            disp_lz_d  = pend_lz_q;
         end
      end else if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_lz_d  = lz_en;
         busy_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q       <= '0;
         digit_q      <= 2'd0;
         pend_val_q   <= 16'h0000;
         pend_dp_q    <= 4'h0;
         pend_lz_q    <= 1'b0;
         disp_val_q   <= 16'h0000;
         disp_dp_q    <= 4'h0;
         disp_lz_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         digit_q      <= digit_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_lz_q    <= pend_lz_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         disp_lz_q    <= disp_lz_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Current nibble and leading-zero blanking from the display register
   always_comb begin
      nibble_c   = disp_val_q[3:0];
      lz_blank_c = 1'b0;
      case (digit_q)
         2'd3: begin
            nibble_c   = disp_val_q[15:12];
            lz_blank_c = disp_lz_q && (disp_val_q[15:12] == 4'h0);
         end
         2'd2: begin
            nibble_c   = disp_val_q[11:8];
            lz_blank_c = disp_lz_q && (disp_val_q[15:8] == 8'h00);
         end
         2'd1: begin
            nibble_c   = disp_val_q[7:4];
            lz_blank_c = disp_lz_q && (disp_val_q[15:4] == 12'h000);
         end
         default: begin
            nibble_c   = disp_val_q[3:0];
            lz_blank_c = 1'b0;
         end
      endcase
   end

   seg7_decoder u_dec (
      .nibble_i (nibble_c),
      .seg_o    (seg_c)
   );

   assign phase_c    = (slot_q < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
   assign drive_c    = (phase_c == PH_DRIVE) && !lz_blank_c;
   assign an         = drive_c ? ~(4'b0001 << digit_q) : 4'b1111;
   assign a_to_g     = drive_c ? seg_c : 7'h7F;
   assign dp         = ~(drive_c & disp_dp_q[digit_q]);
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYCLES = 8, BLANK_CYCLES = 2;
// cycle numbers are counted from the first cycle after reset release.

module tb_seg7_scan_ctrl;
   logic        clk = 1'b0;
   logic        reset, enable, load, lz_en;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  a_to_g;
   logic        dp, busy, frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   seg7_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .an         (an),
      .a_to_g     (a_to_g),
      .dp         (dp),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic adv_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; load = 1'b0; lz_en = 1'b0;
      value = 16'h0000; dp_in = 4'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(a_to_g), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_fd", 16'(frame_done), 16'h0);
      reset = 1'b0;
      cyc = 0;

      // First frame: blanking then digit 0 showing '0'
      chk("c0_an", 16'(an), 16'hF);
      adv_to(1);  chk("c1_an", 16'(an), 16'hF);
      adv_to(2);  chk("c2_an", 16'(an), 16'hE);
      chk("c2_seg", 16'(a_to_g), 16'h01);
      chk("c2_dp", 16'(dp), 16'h1);
      adv_to(5);
      load = 1'b1; value = 16'h1234;
      adv_to(6);  load = 1'b0;
      chk("c6_busy", 16'(busy), 16'h1);
      adv_to(8);  chk("c8_an", 16'(an), 16'hF);
      adv_to(10); chk("c10_an", 16'(an), 16'hD);
      chk("c10_seg", 16'(a_to_g), 16'h01);
      adv_to(31); chk("c31_busy", 16'(busy), 16'h1);
      chk("c31_fd", 16'(frame_done), 16'h0);
      adv_to(32); chk("c32_fd", 16'(frame_done), 16'h1);
      chk("c32_busy", 16'(busy), 16'h0);
      chk("c32_an", 16'(an), 16'hF);
      adv_to(33); chk("c33_fd", 16'(frame_done), 16'h0);
      adv_to(34); chk("c34_an", 16'(an), 16'hE);
      chk("c34_seg4", 16'(a_to_g), 16'h4C);

      // Overwrite pending before the boundary; old display must persist
      adv_to(40);
      load = 1'b1; value = 16'h1111;
      adv_to(41);
      value = 16'h0070; lz_en = 1'b1; dp_in = 4'b0010;
      adv_to(42); load = 1'b0; lz_en = 1'b0; dp_in = 4'h0;
      chk("c42_busy", 16'(busy), 16'h1);
      chk("c42_an", 16'(an), 16'hD);
      chk("c42_seg3", 16'(a_to_g), 16'h06);
      adv_to(50); chk("c50_seg2", 16'(a_to_g), 16'h12);
      adv_to(58); chk("c58_seg1", 16'(a_to_g), 16'h4F);
      adv_to(64); chk("c64_fd", 16'(frame_done), 16'h1);
      chk("c64_busy", 16'(busy), 16'h0);

      // Leading-zero suppression of 0070 with dp on digit 1
      adv_to(66); chk("lz_d0_an", 16'(an), 16'hE);
      chk("lz_d0_seg", 16'(a_to_g), 16'h01);
      chk("lz_d0_dp", 16'(dp), 16'h1);
      adv_to(74); chk("lz_d1_an", 16'(an), 16'hD);
      chk("lz_d1_seg", 16'(a_to_g), 16'h0F);
      chk("lz_d1_dp", 16'(dp), 16'h0);
      adv_to(80); chk("lz_d2_an0", 16'(an), 16'hF);
      adv_to(82); chk("lz_d2_an", 16'(an), 16'hF);
      chk("lz_d2_dp", 16'(dp), 16'h1);
      adv_to(90); chk("lz_d3_an", 16'(an), 16'hF);
      adv_to(95); chk("lz_d3_an_end", 16'(an), 16'hF);

      // Load in the boundary cycle goes straight to display
      load = 1'b1; value = 16'hABCD;
      adv_to(96); load = 1'b0;
      chk("bnd_busy", 16'(busy), 16'h0);
      chk("bnd_fd", 16'(frame_done), 16'h1);
      adv_to(104); chk("bnd_d1_blank", 16'(an), 16'hF);
      adv_to(106); chk("bnd_d1_an", 16'(an), 16'hD);
      chk("bnd_d1_segC", 16'(a_to_g), 16'h31);
      adv_to(114); chk("bnd_d2_segB", 16'(a_to_g), 16'h60);

      // Disable mid-slot; loads still captured, no frame boundary
      adv_to(116); enable = 1'b0;
      adv_to(117); chk("dis_an", 16'(an), 16'hF);
      chk("dis_seg", 16'(a_to_g), 16'h7F);
      chk("dis_dp", 16'(dp), 16'h1);
      adv_to(118); load = 1'b1; value = 16'h5555;
      adv_to(119); load = 1'b0;
      chk("dis_busy", 16'(busy), 16'h1);
      adv_to(128); chk("dis_fd", 16'(frame_done), 16'h0);
      chk("dis_busy_hold", 16'(busy), 16'h1);
      adv_to(150); enable = 1'b1;
      chk("en_c0_an", 16'(an), 16'hF);
      adv_to(151); chk("en_c1_an", 16'(an), 16'hF);
      adv_to(152); chk("en_c2_an", 16'(an), 16'hE);
      adv_to(181); chk("en_busy_pre", 16'(busy), 16'h1);
      adv_to(182); chk("en_fd", 16'(frame_done), 16'h1);
      chk("en_busy", 16'(busy), 16'h0);
      adv_to(184); chk("en_seg5", 16'(a_to_g), 16'h24);

      // Reset mid-frame with a pending value overrides a concurrent load
      adv_to(186); load = 1'b1; value = 16'h9999;
      adv_to(187); load = 1'b0;
      chk("pre_rst_busy", 16'(busy), 16'h1);
      adv_to(190); reset = 1'b1; load = 1'b1; value = 16'h1234;
      adv_to(191); reset = 1'b0; load = 1'b0;
      chk("mrst_busy", 16'(busy), 16'h0);
      chk("mrst_an", 16'(an), 16'hF);
      chk("mrst_fd", 16'(frame_done), 16'h0);
      adv_to(193); chk("mrst_d0_an", 16'(an), 16'hE);
      chk("mrst_d0_seg", 16'(a_to_g), 16'h01);
      adv_to(201); chk("mrst_d1_seg", 16'(a_to_g), 16'h01);
      chk("mrst_busy2", 16'(busy), 16'h0);
      adv_to(223); chk("mrst_fd2", 16'(frame_done), 16'h1);
      adv_to(233); chk("mrst_d1_after", 16'(a_to_g), 16'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
